reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Parametrised register-dependency scoreboard for the 5-stage core; replaces single-entry DR compares.
//  Sits beside decode and counts outstanding writes per architectural register.
//  Stalls issue on RAW hazards or counter saturation, and decrements on writeback retire or branch-flush kill.
//  Allows multiple in-flight writes to the same register, which a per-stage DR compare cannot handle.
// PARAMETERS
//  NREGS     32  architectural registers tracked; x0 is never tracked
//  CNT_W     3   per-register counter width; max in-flight writes per register = 2^CNT_W-1
//  NUM_SRC   2   source operands checked per issue
//  NUM_KILL  3   flushed (killed) in-flight writes reportable per cycle
// PORTS
//  CLK            in   1            clock; all state updates on rising edge
//  RESET          in   1            synchronous, active-high reset
//  ISSUE_V        in   1            decode presents a valid instruction
//  ISSUE_SRC      in   NUM_SRC*5    packed source register numbers; src i at [5i+4:5i]
//  ISSUE_SRC_USE  in   NUM_SRC      bit i set = src i is actually read
//  ISSUE_WEN      in   1            instruction writes a destination register
//  ISSUE_DR       in   5            destination register number
//  ISSUE_STALL    out  1            combinational; hold decode this cycle
//  ISSUE_ACCEPT   out  1            combinational; ISSUE_V & ~ISSUE_STALL
//  RETIRE_V       in   1            writeback commits a register write this cycle
//  RETIRE_DR      in   5            register committed by writeback
//  KILL_V         in   NUM_KILL     bit k set = squashed in-flight write k
//  KILL_DR        in   NUM_KILL*5   packed DRs of squashed writes
//  BUSY           out  NREGS        registered; bit r = cnt[r]!=0 (bit 0 always 0)
//  EMPTY          out  1            registered; no outstanding writes in any register
//  CNT_ERR        out  1            registered, sticky; counter underflow was detected
// BEHAVIOUR
//  Reset (sync): all cnt[r]=0, BUSY=0, EMPTY=1, CNT_ERR=0. ISSUE_STALL=0 while ISSUE_V=0.
//  Reset mid-operation discards all counts; pending RETIRE/KILL in the reset cycle are ignored.
//  State: cnt[r], CNT_W bits, for r=1..NREGS-1. cnt[0] does not exist and reads as 0.
//  Register numbers >= NREGS are ignored on every input.
//  Stall is evaluated only on registered cnt; there is no same-cycle retire bypass. ISSUE_STALL=ISSUE_V & (raw | sat):
//    raw = any i: SRC_USE[i] & SRC[i]!=0 & cnt[SRC[i]]!=0
//    sat = ISSUE_WEN & ISSUE_DR!=0 & cnt[ISSUE_DR]==2^CNT_W-1
//  Per-cycle update for each r:
//    inc = ISSUE_ACCEPT & ISSUE_WEN & ISSUE_DR==r
//    dec = (RETIRE_V & RETIRE_DR==r) + popcount over k of (KILL_V[k] & KILL_DR[k]==r)
//  Arithmetic: next = cnt+inc-dec, computed in CNT_W+2 signed bits.
//    If next<0: cnt<=0 and CNT_ERR<=1.
//    Otherwise cnt<=next. next cannot exceed max, because sat blocks the increment.
//  Simultaneous issue and retire/kill on the same register nets out in the same cycle (e.g. 1+1-1=1).
//  Latency: BUSY and EMPTY reflect an accepted issue or a retire one cycle after the edge.
//  Self-dependence (SRC==DR) stalls only on prior writes, never on itself.
//  CNT_ERR clears only on RESET.
//  Kill contract: control reports every squashed write exactly once; a killed write is never also retired.
// TESTING
//  T1 Reset: assert RESET for 2 cycles -> BUSY=0, EMPTY=1, CNT_ERR=0, ISSUE_STALL=0.
//  T2 RAW: accept WEN DR=5; next cycle SRC0=5 USE=01 -> STALL=1.
//     RETIRE_DR=5 -> STALL stays 1 that cycle, goes 0 the next cycle.
//  T3 x0: issue WEN DR=0 -> BUSY=0, EMPTY=1; SRC0=0 with USE=1 -> STALL=0 always.
//  T4 Saturation, CNT_W=2: accept three WEN DR=7 -> 4th WEN DR=7 gives STALL=1.
//     RETIRE_DR=7 -> 4th accepted next cycle and BUSY[7] stays 1.
//  T5 Simultaneous events: cnt[3]=1; issue WEN DR=3 with RETIRE_DR=3 same cycle -> cnt[3]=1, BUSY[3]=1.
//  T6 Flush: cnt[4]=2; KILL_V=011 both DR=4 -> BUSY[4]=0, EMPTY=1.
//     Then RETIRE_DR=4 -> CNT_ERR=1, cnt[4] remains 0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: counts in-flight writes per architectural register,
// stalls issue on RAW hazards or counter saturation, and retires/kills outstanding writes.
module reg_scoreboard #(
  parameter int NREGS    = 32,
  parameter int CNT_W    = 3,
  parameter int NUM_SRC  = 2,
  parameter int NUM_KILL = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ISSUE_V,
  input  logic [NUM_SRC*5-1:0]  ISSUE_SRC,
  input  logic [NUM_SRC-1:0]    ISSUE_SRC_USE,
  input  logic                  ISSUE_WEN,
  input  logic [4:0]            ISSUE_DR,
  output logic                  ISSUE_STALL,
  output logic                  ISSUE_ACCEPT,
  input  logic                  RETIRE_V,
  input  logic [4:0]            RETIRE_DR,
  input  logic [NUM_KILL-1:0]   KILL_V,
  input  logic [NUM_KILL*5-1:0] KILL_DR,
  output logic [NREGS-1:0]      BUSY,
  output logic                  EMPTY,
  output logic                  CNT_ERR
);

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [CNT_W+1:0] ONE     = 1;

  logic [CNT_W-1:0] cnt      [NREGS];
  logic [CNT_W-1:0] cnt_next [NREGS];
  logic [NREGS-1:0] under;
  logic             raw;
  logic             sat;
  logic             cnt_err_q;

  // Hazard detection looks only at registered counts; compares against every register
  // number so out-of-range source/destination numbers simply never match.
  // NOTE: every variable written in an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    raw = 1'b0;
    sat = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (ISSUE_SRC_USE[i] && ISSUE_SRC[5*i +: 5] == 5'(r) && cnt[r] != '0) raw = 1'b1;
      end
    end
    for (int r = 1; r < NREGS; r++) begin
      if (ISSUE_WEN && ISSUE_DR == 5'(r) && cnt[r] == CNT_MAX) sat = 1'b1;
    end
  end

  assign ISSUE_STALL  = ISSUE_V & (raw | sat);
  assign ISSUE_ACCEPT = ISSUE_V & ~ISSUE_STALL;

  // Net increment/decrement per register in a signed width wide enough for cnt+1-(1+NUM_KILL).
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      logic signed [CNT_W+1:0] nxt;
      nxt = {2'b00, cnt[r]};
      if (ISSUE_ACCEPT && ISSUE_WEN && ISSUE_DR == 5'(r)) nxt = nxt + ONE;
      if (RETIRE_V && RETIRE_DR == 5'(r)) nxt = nxt - ONE;
      for (int k = 0; k < NUM_KILL; k++) begin
        if (KILL_V[k] && KILL_DR[5*k +: 5] == 5'(r)) nxt = nxt - ONE;
      end
      under[r]    = nxt[CNT_W+1];
      cnt_next[r] = under[r] ? '0 : nxt[CNT_W-1:0];
      if (r == 0) begin
        under[r]    = 1'b0;
        cnt_next[r] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the counter array is reset explicitly; it is a bank of flops, not a RAM,
  // and stale counts after reset would stall decode forever.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_next[r];
      if (|under) cnt_err_q <= 1'b1;
    end
  end

  always_comb begin
    BUSY = '0;
    for (int r = 1; r < NREGS; r++) BUSY[r] = (cnt[r] != '0);
  end

  assign EMPTY   = ~|BUSY;
  assign CNT_ERR = cnt_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_W=2 so saturation is reachable quickly).
module tb_reg_scoreboard;

  localparam int NREGS    = 32;
  localparam int CNT_W    = 2;
  localparam int NUM_SRC  = 2;
  localparam int NUM_KILL = 3;

  logic                  CLK;
  logic                  RESET;
  logic                  ISSUE_V;
  logic [NUM_SRC*5-1:0]  ISSUE_SRC;
  logic [NUM_SRC-1:0]    ISSUE_SRC_USE;
  logic                  ISSUE_WEN;
  logic [4:0]            ISSUE_DR;
  logic                  ISSUE_STALL;
  logic                  ISSUE_ACCEPT;
  logic                  RETIRE_V;
  logic [4:0]            RETIRE_DR;
  logic [NUM_KILL-1:0]   KILL_V;
  logic [NUM_KILL*5-1:0] KILL_DR;
  logic [NREGS-1:0]      BUSY;
  logic                  EMPTY;
  logic                  CNT_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  reg_scoreboard #(
    .NREGS(NREGS), .CNT_W(CNT_W), .NUM_SRC(NUM_SRC), .NUM_KILL(NUM_KILL)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .ISSUE_V(ISSUE_V), .ISSUE_SRC(ISSUE_SRC), .ISSUE_SRC_USE(ISSUE_SRC_USE),
    .ISSUE_WEN(ISSUE_WEN), .ISSUE_DR(ISSUE_DR),
    .ISSUE_STALL(ISSUE_STALL), .ISSUE_ACCEPT(ISSUE_ACCEPT),
    .RETIRE_V(RETIRE_V), .RETIRE_DR(RETIRE_DR),
    .KILL_V(KILL_V), .KILL_DR(KILL_DR),
    .BUSY(BUSY), .EMPTY(EMPTY), .CNT_ERR(CNT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ISSUE_V       = 1'b0;
    ISSUE_SRC     = '0;
    ISSUE_SRC_USE = '0;
    ISSUE_WEN     = 1'b0;
    ISSUE_DR      = '0;
    RETIRE_V      = 1'b0;
    RETIRE_DR     = '0;
    KILL_V        = '0;
    KILL_DR       = '0;
  endtask

  task automatic issue_write(input logic [4:0] dr);
    clear_inputs();
    ISSUE_V   = 1'b1;
    ISSUE_WEN = 1'b1;
    ISSUE_DR  = dr;
  endtask

  task automatic retire(input logic [4:0] dr);
    clear_inputs();
    RETIRE_V  = 1'b1;
    RETIRE_DR = dr;
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();

    // T1 reset
    tick();
    tick();
    check("rst_busy", BUSY, 32'h0);
    check("rst_empty", EMPTY, 1);
    check("rst_err", CNT_ERR, 0);
    check("rst_stall", ISSUE_STALL, 0);
    RESET = 1'b0;

    // T2 RAW hazard on r5, retire not bypassed
    issue_write(5'd5);
    #1;
    check("t2_accept_wr", ISSUE_ACCEPT, 1);
    tick();
    check("t2_busy5", BUSY, 32'h20);
    check("t2_not_empty", EMPTY, 0);
    clear_inputs();
    ISSUE_V = 1'b1; ISSUE_SRC = {5'd0, 5'd5}; ISSUE_SRC_USE = 2'b01;
    #1;
    check("t2_raw_stall", ISSUE_STALL, 1);
    check("t2_raw_noacc", ISSUE_ACCEPT, 0);
    RETIRE_V = 1'b1; RETIRE_DR = 5'd5;
    #1;
    check("t2_no_bypass", ISSUE_STALL, 1);
    tick();
    RETIRE_V = 1'b0;
    #1;
    check("t2_stall_clear", ISSUE_STALL, 0);
    check("t2_busy_clear", BUSY, 32'h0);
    check("t2_empty", EMPTY, 1);

    // Self-dependence and source-1 lookup on r6
    issue_write(5'd6);
    ISSUE_SRC = {5'd0, 5'd6}; ISSUE_SRC_USE = 2'b01;
    #1;
    check("self_dep_nostall", ISSUE_STALL, 0);
    tick();
    check("self_dep_busy6", BUSY, 32'h40);
    clear_inputs();
    ISSUE_V = 1'b1; ISSUE_SRC = {5'd6, 5'd0}; ISSUE_SRC_USE = 2'b10;
    #1;
    check("src1_raw", ISSUE_STALL, 1);
    ISSUE_SRC_USE = 2'b01;
    #1;
    check("src1_unused", ISSUE_STALL, 0);
    ISSUE_SRC = {5'd6, 5'd6}; ISSUE_SRC_USE = 2'b00;
    #1;
    check("use_mask_zero", ISSUE_STALL, 0);
    retire(5'd6);
    tick();
    clear_inputs();
    check("r6_retired", BUSY, 32'h0);

    // T3 x0 never tracked
    issue_write(5'd0);
    tick();
    check("t3_busy", BUSY, 32'h0);
    check("t3_empty", EMPTY, 1);
    clear_inputs();
    ISSUE_V = 1'b1; ISSUE_SRC = {5'd0, 5'd0}; ISSUE_SRC_USE = 2'b11;
    #1;
    check("t3_src_x0", ISSUE_STALL, 0);

    // T4 saturation on r7 (max 3)
    for (int n = 0; n < 3; n++) begin
      issue_write(5'd7);
      #1;
      check($sformatf("t4_acc%0d", n), ISSUE_ACCEPT, 1);
      tick();
    end
    check("t4_busy7", BUSY, 32'h80);
    issue_write(5'd7);
    #1;
    check("t4_sat_stall", ISSUE_STALL, 1);
    RETIRE_V = 1'b1; RETIRE_DR = 5'd7;
    #1;
    check("t4_sat_no_bypass", ISSUE_STALL, 1);
    tick();
    RETIRE_V = 1'b0;
    #1;
    check("t4_4th_accept", ISSUE_ACCEPT, 1);
    tick();
    clear_inputs();
    check("t4_busy7_kept", BUSY, 32'h80);
    KILL_V = 3'b111; KILL_DR = {5'd7, 5'd7, 5'd7};
    tick();
    clear_inputs();
    check("t4_killed3", BUSY, 32'h0);
    check("t4_no_err", CNT_ERR, 0);

    // T5 simultaneous issue + retire on r3 nets out
    issue_write(5'd3);
    tick();
    issue_write(5'd3);
    RETIRE_V = 1'b1; RETIRE_DR = 5'd3;
    #1;
    check("t5_accept", ISSUE_ACCEPT, 1);
    tick();
    check("t5_busy3", BUSY, 32'h8);
    retire(5'd3);
    tick();
    clear_inputs();
    check("t5_cnt_was_1", BUSY, 32'h0);
    check("t5_no_err", CNT_ERR, 0);

    // T6 flush two writes to r4, then an extra retire underflows
    issue_write(5'd4);
    tick();
    issue_write(5'd4);
    tick();
    clear_inputs();
    check("t6_busy4", BUSY, 32'h10);
    KILL_V = 3'b011; KILL_DR = {5'd0, 5'd4, 5'd4};
    tick();
    clear_inputs();
    check("t6_killed", BUSY, 32'h0);
    check("t6_empty", EMPTY, 1);
    check("t6_err_pre", CNT_ERR, 0);
    retire(5'd4);
    tick();
    clear_inputs();
    check("t6_underflow", CNT_ERR, 1);
    check("t6_clamped", BUSY, 32'h0);
    issue_write(5'd4);
    tick();
    retire(5'd4);
    tick();
    clear_inputs();
    check("t6_clamped_zero", BUSY, 32'h0);
    check("t6_err_sticky", CNT_ERR, 1);

    // Reset mid-operation ignores pending kills on r9
    issue_write(5'd9);
    tick();
    clear_inputs();
    check("mid_busy9", BUSY, 32'h200);
    RESET = 1'b1;
    KILL_V = 3'b011; KILL_DR = {5'd0, 5'd9, 5'd9};
    tick();
    RESET = 1'b0;
    clear_inputs();
    #1;
    check("mid_rst_busy", BUSY, 32'h0);
    check("mid_rst_err", CNT_ERR, 0);
    check("mid_rst_empty", EMPTY, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
